// File: rtl/alu_seq.sv
// Multi-cycle ALU: add/sub/shift in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Define ALU_SEQ_SHIFT_EN to enable opcode 1100 as a logical shift; otherwise it is reported as illegal.
module alu_seq #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SHAMT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               carry_in,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               shift_dir,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Y,
    output logic               carry_out,
    output logic [WIDTH-1:0]   product_high,
    output logic [WIDTH-1:0]   remainder,
    output logic               valid_div,
    output logic               err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 2);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;
`ifdef ALU_SEQ_SHIFT_EN
    localparam logic [3:0] OP_SHF = 4'b1100;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 mul_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 is_mul_c;
    logic                 need_calc_c;
    logic [2*WIDTH-1:0]   first_c;
    logic [2*WIDTH-1:0]   calc_c;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_dif;
    logic [WIDTH-1:0]     sc_y;
    logic                 sc_co;
    logic [WIDTH-1:0]     sc_rem;
    logic                 sc_err;

    // One iteration. Mul: hi accumulates, lo holds multiplier then product low bits.
    // Div: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    function automatic logic [2*WIDTH-1:0] step(
        input logic             is_mul,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]     sum;
        logic [WIDTH:0]     shl;
        logic [WIDTH-1:0]   dif;
        logic               ok;
        logic [2*WIDTH-1:0] res;
        sum = '0;
        shl = '0;
        dif = '0;
        ok  = 1'b0;
        res = '0;
        if (is_mul) begin
            sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
            res = {sum, lo[WIDTH-1:1]};
        end else begin
            shl = {hi, lo[WIDTH-1]};
            ok  = (shl >= {1'b0, b});
            dif = WIDTH'(shl - {1'b0, b});
            res = {(ok ? dif : shl[WIDTH-1:0]), lo[WIDTH-2:0], ok};
        end
        return res;
    endfunction

    // The accepting edge already performs the first iteration, so WIDTH-1 CALC edges remain.
    always_comb begin
        is_mul_c    = (opcode == OP_MUL);
        need_calc_c = is_mul_c || ((opcode == OP_DIV) && (B != '0));
        first_c     = step(is_mul_c, '0, (is_mul_c ? B : A), A, B);
        calc_c      = step(mul_r, hi_r, lo_r, a_r, b_r);
    end

`ifdef ALU_SEQ_SHIFT_EN
    int unsigned      sh;
    logic [WIDTH:0]   shl_v;
    logic [WIDTH:0]   shr_v;

    // Extra guard bit on each side catches the last bit shifted out.
    always_comb begin
        sh    = 32'(shift_amt) % WIDTH;
        shl_v = {1'b0, A} << sh;
        shr_v = {A, 1'b0} >> sh;
    end
`else
    logic unused_shift;
    assign unused_shift = ^{shift_amt, shift_dir};
`endif

    // Results for ops that complete on the accepting edge.
    always_comb begin
        sc_y    = '0;
        sc_co   = 1'b0;
        sc_rem  = '0;
        sc_err  = 1'b0;
        add_sum = {1'b0, A} + {1'b0, B} + (WIDTH + 1)'(carry_in);
        sub_dif = {1'b0, A} - {1'b0, B};
        case (opcode)
            OP_ADD: {sc_co, sc_y} = add_sum;
            OP_SUB: begin
                sc_y  = sub_dif[WIDTH-1:0];
                sc_co = sub_dif[WIDTH];
            end
            OP_MUL: sc_err = 1'b0;
            OP_DIV: sc_rem = A;
`ifdef ALU_SEQ_SHIFT_EN
            OP_SHF: begin
                if (shift_dir) begin
                    sc_y  = shr_v[WIDTH:1];
                    sc_co = shr_v[0];
                end else begin
                    sc_y  = shl_v[WIDTH-1:0];
                    sc_co = shl_v[WIDTH];
                end
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // Control FSM, iteration registers and registered result fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            Y            <= '0;
            carry_out    <= 1'b0;
            product_high <= '0;
            remainder    <= '0;
            valid_div    <= 1'b0;
            err          <= 1'b0;
            mul_r        <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            hi_r         <= '0;
            lo_r         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        mul_r <= is_mul_c;
                        a_r   <= A;
                        b_r   <= B;
                        if (need_calc_c) begin
                            state         <= S_CALC;
                            busy          <= 1'b1;
                            cnt           <= '0;
                            {hi_r, lo_r}  <= first_c;
                        end else begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            Y            <= sc_y;
                            carry_out    <= sc_co;
                            product_high <= '0;
                            remainder    <= sc_rem;
                            valid_div    <= 1'b0;
                            err          <= sc_err;
                        end
                    end
                end
                S_CALC: begin
                    {hi_r, lo_r} <= calc_c;
                    cnt          <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        cnt          <= '0;
                        Y            <= calc_c[WIDTH-1:0];
                        carry_out    <= 1'b0;
                        product_high <= mul_r ? calc_c[2*WIDTH-1:WIDTH] : '0;
                        remainder    <= mul_r ? '0 : calc_c[2*WIDTH-1:WIDTH];
                        valid_div    <= ~mul_r;
                        err          <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
